// File: rtl/lsu_sequencer.sv
// rtl/lsu_sequencer.sv - RV32I load/store sequencer: byte enables, lane shifting, misaligned split, timeout
module lsu_sequencer #(
    parameter int SPLIT_MISALIGNED = 1,
    parameter int TIMEOUT_CYCLES   = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] load_data,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [3:0]  mem_byte_enable,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp
);

    typedef enum logic [2:0] {S_IDLE, S_ACC1, S_ACC2, S_DONE, S_ERR} state_t;

    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_t      state, state_n;
    logic        is_store_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [31:0] lo_q;
    logic [31:0] load_data_q;
    logic [31:0] cnt_q;

    function automatic logic [3:0] size_mask(input logic [1:0] sz);
        case (sz)
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic f3_legal(input logic st, input logic [2:0] f3);
        if (st)
            return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
        return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
               (f3 == 3'b100) || (f3 == 3'b101);
    endfunction

    // An access crosses the word boundary when its last byte lands past lane 3.
    function automatic logic crosses(input logic [1:0] sz, input logic [1:0] off);
        logic [2:0] last;
        last = (sz == 2'b00) ? 3'd0 : (sz == 2'b01) ? 3'd1 : 3'd3;
        return ({1'b0, off} + last) > 3'd3;
    endfunction

    logic        split_in;
    logic        split_q;
    logic [7:0]  m8_q;
    logic [63:0] w64_q;
    logic [63:0] fin64;
    logic [31:0] sel;
    logic [31:0] ext;
    logic        timeout_hit;
    logic        last_resp;

    assign split_in    = crosses(funct3[1:0], addr[1:0]);
    assign split_q     = crosses(funct3_q[1:0], addr_q[1:0]);
    assign m8_q        = {4'b0000, size_mask(funct3_q[1:0])} << addr_q[1:0];
    assign w64_q       = {32'd0, data_q} << {addr_q[1:0], 3'b000};
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);

    // The upper word is zero unless this is the second half of a split access.
    assign fin64 = (state == S_ACC2) ? {mem_rdata, lo_q} : {32'd0, mem_rdata};
    assign sel   = 32'(fin64 >> {addr_q[1:0], 3'b000});

    always_comb begin
        case (funct3_q)
            3'b000:  ext = {{24{sel[7]}}, sel[7:0]};
            3'b001:  ext = {{16{sel[15]}}, sel[15:0]};
            3'b100:  ext = {24'd0, sel[7:0]};
            3'b101:  ext = {16'd0, sel[15:0]};
            default: ext = sel;
        endcase
    end

    assign last_resp = mem_resp && ((state == S_ACC1 && !split_q) || state == S_ACC2);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            is_store_q  <= 1'b0;
            funct3_q    <= 3'd0;
            addr_q      <= 32'd0;
            data_q      <= 32'd0;
            lo_q        <= 32'd0;
            load_data_q <= 32'd0;
            cnt_q       <= 32'd0;
        end else begin
            state <= state_n;
            cnt_q <= (state_n != state) ? 32'd0 : cnt_q + 32'd1;
            if (state == S_IDLE && start) begin
                is_store_q <= is_store;
                funct3_q   <= funct3;
                addr_q     <= addr;
                data_q     <= store_data;
            end
            if (state == S_ACC1 && mem_resp)
                lo_q <= mem_rdata;
            if (last_resp && !is_store_q)
                load_data_q <= ext;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (!f3_legal(is_store, funct3))
                        state_n = S_ERR;
                    else if (split_in && SPLIT_MISALIGNED == 0)
                        state_n = S_ERR;
                    else
                        state_n = S_ACC1;
                end
            end
            S_ACC1: begin
                if (mem_resp)
                    state_n = split_q ? S_ACC2 : S_DONE;
                else if (timeout_hit)
                    state_n = S_ERR;
            end
            S_ACC2: begin
                if (mem_resp)
                    state_n = S_DONE;
                else if (timeout_hit)
                    state_n = S_ERR;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        busy            = (state != S_IDLE);
        done            = 1'b0;
        err             = 1'b0;
        mem_address     = 32'd0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_byte_enable = 4'd0;
        mem_wdata       = 32'd0;
        case (state)
            S_ACC1: begin
                mem_address     = {addr_q[31:2], 2'b00};
                mem_read        = !is_store_q;
                mem_write       = is_store_q;
                mem_byte_enable = m8_q[3:0];
                mem_wdata       = w64_q[31:0];
            end
            S_ACC2: begin
                mem_address     = {addr_q[31:2], 2'b00} + 32'd4;
                mem_read        = !is_store_q;
                mem_write       = is_store_q;
                mem_byte_enable = m8_q[7:4];
                mem_wdata       = w64_q[63:32];
            end
            S_DONE: done = 1'b1;
            S_ERR: begin
                done = 1'b1;
                err  = 1'b1;
            end
            default: ;
        endcase
    end

    assign load_data = load_data_q;

endmodule

// File: tb/tb_lsu_sequencer.sv
// tb/tb_lsu_sequencer.sv - directed self-checking bench for lsu_sequencer
module tb_lsu_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, is_store;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data, mem_rdata;
    logic        mem_resp;
    logic        busy, done, err, mem_read, mem_write;
    logic [31:0] load_data, mem_address, mem_wdata;
    logic [3:0]  mem_be;

    logic        rst_b, start_b, mem_resp_b;
    logic [31:0] mem_rdata_b;
    logic        busy_b, done_b, err_b, mem_read_b, mem_write_b;
    logic [31:0] load_data_b, mem_address_b, mem_wdata_b;
    logic [3:0]  mem_be_b;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    lsu_sequencer #(.SPLIT_MISALIGNED(1), .TIMEOUT_CYCLES(8)) dut_a (
        .clk(clk), .rst(rst), .start(start), .is_store(is_store), .funct3(funct3),
        .addr(addr), .store_data(store_data), .busy(busy), .done(done), .err(err),
        .load_data(load_data), .mem_address(mem_address), .mem_read(mem_read),
        .mem_write(mem_write), .mem_byte_enable(mem_be), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    lsu_sequencer #(.SPLIT_MISALIGNED(0), .TIMEOUT_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .is_store(is_store), .funct3(funct3),
        .addr(addr), .store_data(store_data), .busy(busy_b), .done(done_b), .err(err_b),
        .load_data(load_data_b), .mem_address(mem_address_b), .mem_read(mem_read_b),
        .mem_write(mem_write_b), .mem_byte_enable(mem_be_b), .mem_wdata(mem_wdata_b),
        .mem_rdata(mem_rdata_b), .mem_resp(mem_resp_b)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d);
        start = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = d;
        cyc();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rst_b = 1'b1;
        cyc(); cyc();
        rst = 1'b0; rst_b = 1'b0;
        cyc();
        tests++; if ({busy, done, err, mem_read, mem_write} !== 5'b0) begin
            fails++; $display("FAIL reset_ctrl got %b want 00000", {busy, done, err, mem_read, mem_write}); end
        tests++; if (load_data !== 32'd0) begin
            fails++; $display("FAIL reset_load_data got %h want 00000000", load_data); end
        tests++; if ({mem_be, mem_address, mem_wdata} !== 68'd0) begin
            fails++; $display("FAIL reset_mem got %h want 0", {mem_be, mem_address, mem_wdata}); end
        tests++; if ({busy_b, done_b, mem_read_b} !== 3'b0) begin
            fails++; $display("FAIL reset_b got %b want 000", {busy_b, done_b, mem_read_b}); end
    endtask

    task automatic test_lw();
        issue(1'b0, 3'b010, 32'h100, 32'h0);
        tests++; if ({mem_read, mem_write, mem_be, mem_address} !== {1'b1, 1'b0, 4'hF, 32'h100}) begin
            fails++; $display("FAIL lw_req got %b %b %h %h want 1 0 f 00000100", mem_read, mem_write, mem_be, mem_address); end
        cyc(); cyc();
        tests++; if ({mem_read, busy, done} !== 3'b110) begin
            fails++; $display("FAIL lw_wait got %b want 110", {mem_read, busy, done}); end
        mem_resp = 1'b1; mem_rdata = 32'hDEADBEEF;
        cyc();
        mem_resp = 1'b0;
        tests++; if ({done, err, mem_read} !== 3'b100 || load_data !== 32'hDEADBEEF) begin
            fails++; $display("FAIL lw_done got %b %h want 100 deadbeef", {done, err, mem_read}, load_data); end
        cyc();
        tests++; if ({done, busy} !== 2'b00 || load_data !== 32'hDEADBEEF) begin
            fails++; $display("FAIL lw_hold got %b %h want 00 deadbeef", {done, busy}, load_data); end
    endtask

    task automatic test_byte_half();
        logic [2:0]  f3s [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] ads [4] = '{32'h103, 32'h103, 32'h102, 32'h102};
        logic [3:0]  bes [4] = '{4'b1000, 4'b1000, 4'b1100, 4'b1100};
        logic [31:0] exp [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8012, 32'h00008012};
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, f3s[i], ads[i], 32'h0);
            tests++; if (mem_be !== bes[i] || mem_address !== 32'h100) begin
                fails++; $display("FAIL bh_be[%0d] got %b %h want %b 00000100", i, mem_be, mem_address, bes[i]); end
            mem_resp = 1'b1; mem_rdata = 32'h80123456;
            cyc();
            mem_resp = 1'b0;
            tests++; if (done !== 1'b1 || load_data !== exp[i]) begin
                fails++; $display("FAIL bh_data[%0d] got %b %h want 1 %h", i, done, load_data, exp[i]); end
            cyc();
        end
    endtask

    task automatic test_split_load();
        issue(1'b0, 3'b010, 32'h101, 32'h0);
        tests++; if (mem_be !== 4'b1110 || mem_address !== 32'h100) begin
            fails++; $display("FAIL splitld_lo got %b %h want 1110 00000100", mem_be, mem_address); end
        mem_resp = 1'b1; mem_rdata = 32'h44332211;
        cyc();
        mem_rdata = 32'h88776655;
        tests++; if ({mem_read, done} !== 2'b10 || mem_be !== 4'b0001 || mem_address !== 32'h104) begin
            fails++; $display("FAIL splitld_hi got %b %b %h want 10 0001 00000104", {mem_read, done}, mem_be, mem_address); end
        cyc();
        mem_resp = 1'b0;
        tests++; if (done !== 1'b1 || load_data !== 32'h55443322) begin
            fails++; $display("FAIL splitld_data got %b %h want 1 55443322", done, load_data); end
        cyc();
    endtask

    task automatic test_split_store();
        issue(1'b1, 3'b010, 32'h102, 32'h11223344);
        tests++; if ({mem_write, mem_read, mem_be, mem_address, mem_wdata} !== {1'b1, 1'b0, 4'b1100, 32'h100, 32'h33440000}) begin
            fails++; $display("FAIL sw_lo got %b %b %b %h %h want 1 0 1100 00000100 33440000", mem_write, mem_read, mem_be, mem_address, mem_wdata); end
        mem_resp = 1'b1;
        cyc();
        tests++; if ({mem_write, done, mem_be, mem_address, mem_wdata} !== {1'b1, 1'b0, 4'b0011, 32'h104, 32'h00001122}) begin
            fails++; $display("FAIL sw_hi got %b %b %b %h %h want 1 0 0011 00000104 00001122", mem_write, done, mem_be, mem_address, mem_wdata); end
        cyc();
        mem_resp = 1'b0;
        tests++; if ({done, err, mem_write} !== 3'b100 || load_data !== 32'h55443322) begin
            fails++; $display("FAIL sw_done got %b %h want 100 55443322", {done, err, mem_write}, load_data); end
        cyc();
        tests++; if ({done, busy} !== 2'b00) begin
            fails++; $display("FAIL sw_single_done got %b want 00", {done, busy}); end
    endtask

    task automatic test_bad_funct3();
        issue(1'b0, 3'b011, 32'h100, 32'h0);
        tests++; if ({done, err, mem_read, mem_write} !== 4'b1100) begin
            fails++; $display("FAIL badf3_load got %b want 1100", {done, err, mem_read, mem_write}); end
        cyc();
        issue(1'b1, 3'b100, 32'h100, 32'h0);
        tests++; if ({done, err, mem_read, mem_write} !== 4'b1100) begin
            fails++; $display("FAIL badf3_store got %b want 1100", {done, err, mem_read, mem_write}); end
        cyc();
        tests++; if (busy !== 1'b0) begin
            fails++; $display("FAIL badf3_idle got %b want 0", busy); end
    endtask

    task automatic test_misaligned_err();
        start_b = 1'b1; is_store = 1'b0; funct3 = 3'b001; addr = 32'h103;
        tests++; if (mem_read_b !== 1'b0) begin
            fails++; $display("FAIL mis_pre got %b want 0", mem_read_b); end
        cyc();
        start_b = 1'b0;
        tests++; if ({done_b, err_b, mem_read_b, mem_write_b} !== 4'b1100) begin
            fails++; $display("FAIL mis_err got %b want 1100", {done_b, err_b, mem_read_b, mem_write_b}); end
        cyc();
        tests++; if ({done_b, busy_b, mem_read_b} !== 3'b000) begin
            fails++; $display("FAIL mis_after got %b want 000", {done_b, busy_b, mem_read_b}); end
    endtask

    task automatic test_timeout();
        int  high_cycles = 0;
        logic seen = 1'b0;
        logic err_seen = 1'b0;
        issue(1'b0, 3'b010, 32'h200, 32'h0);
        for (int i = 0; i < 20; i++) begin
            if (mem_read) high_cycles++;
            if (done) begin
                seen = 1'b1;
                err_seen = err;
                break;
            end
            cyc();
        end
        tests++; if (seen !== 1'b1 || err_seen !== 1'b1) begin
            fails++; $display("FAIL timeout_done got done=%b err=%b want 1 1", seen, err_seen); end
        tests++; if (high_cycles != 8) begin
            fails++; $display("FAIL timeout_len got %0d want 8", high_cycles); end
        cyc();
        tests++; if ({busy, done} !== 2'b00) begin
            fails++; $display("FAIL timeout_idle got %b want 00", {busy, done}); end
    endtask

    task automatic test_reset_mid();
        start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h101;
        cyc();
        mem_resp = 1'b1; mem_rdata = 32'hAAAAAAAA;
        cyc();
        mem_resp = 1'b0;
        tests++; if (mem_read !== 1'b1 || mem_address !== 32'h104) begin
            fails++; $display("FAIL rstmid_acc2 got %b %h want 1 00000104", mem_read, mem_address); end
        rst = 1'b1;
        cyc();
        tests++; if ({mem_read, busy, done} !== 3'b000) begin
            fails++; $display("FAIL rstmid_abort got %b want 000", {mem_read, busy, done}); end
        rst = 1'b0; addr = 32'h100;
        cyc();
        start = 1'b0;
        tests++; if (mem_read !== 1'b1 || mem_address !== 32'h100 || done !== 1'b0) begin
            fails++; $display("FAIL rstmid_restart got %b %h %b want 1 00000100 0", mem_read, mem_address, done); end
        mem_resp = 1'b1; mem_rdata = 32'h12345678;
        cyc();
        mem_resp = 1'b0;
        tests++; if ({done, err} !== 2'b10 || load_data !== 32'h12345678) begin
            fails++; $display("FAIL rstmid_done got %b %h want 10 12345678", {done, err}, load_data); end
        cyc();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = 3'd0; addr = 32'd0;
        store_data = 32'd0; mem_rdata = 32'd0; mem_resp = 1'b0;
        rst_b = 1'b1; start_b = 1'b0; mem_resp_b = 1'b0; mem_rdata_b = 32'd0;
        test_reset();
        test_lw();
        test_byte_half();
        test_split_load();
        test_split_store();
        test_bad_funct3();
        test_misaligned_err();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
